k423_if_ras: RTL and testbench
==============================

Name: k423_if_ras

Overview:
- Return address stack for the fetch-stage branch prediction unit.
- Consumes the fetch-stage mini-decode call/return flags and the fetch PC.
- Pushes the return address on a call and supplies the predicted target for a return.
- Keeps a speculative stack, updated at fetch, and a committed stack, updated at retire. On a pipeline flush the committed stack is copied into the speculative one.

Parameters:
- RAS_DEPTH, 8, number of entries; power of two, at least 2.
- RAS_PTR_W, $clog2(RAS_DEPTH), width of the top-of-stack pointer.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  reset, asynchronous, active-high
- flush_i  input  1  backend redirect; restores the speculative stack from the committed stack
- if_vld_i  input  1  fetch instruction accepted this cycle (valid & ready)
- if_pc_i  input  `CORE_XLEN  PC of the fetched instruction
- dec_call_i  input  1  mini-decode call flag (JAL/JALR with rd = x1 or x5)
- dec_ret_i  input  1  mini-decode return flag
- cmt_vld_i  input  1  instruction retiring this cycle
- cmt_pc_i  input  `CORE_XLEN  PC of the retiring instruction
- cmt_call_i  input  1  retiring instruction is a call
- cmt_ret_i  input  1  retiring instruction is a return
- ras_vld_o  output  1  speculative stack is non-empty
- ras_tgt_o  output  `CORE_XLEN  speculative top entry (predicted return target)
- ras_cnt_o  output  $clog2(RAS_DEPTH+1)  speculative occupancy

Behaviour:
- Storage: two circular arrays, spec and cmt, each RAS_DEPTH x `CORE_XLEN`.
  - Each array has a top pointer (ptr = index of the top entry) and a count.
- Reset: both pointers = RAS_DEPTH-1, both counts = 0, entries = 0, ras_vld_o = 0, ras_tgt_o = 0, ras_cnt_o = 0.
- Outputs are combinational from the speculative registers:
  - ras_tgt_o = spec[spec_ptr]
  - ras_vld_o = (spec_cnt != 0)
  - ras_cnt_o = spec_cnt
- A return fetched in cycle N uses ras_tgt_o in cycle N. The pop takes effect at the edge ending cycle N.
- Operations apply to each stack on the clock edge. The operation is chosen from {fire, call, ret}, where fire is if_vld_i for spec and cmt_vld_i for cmt:
  - push (call & !ret):
    - ptr <= ptr+1 (mod RAS_DEPTH)
    - entry[ptr+1] <= pc+4
    - cnt <= min(cnt+1, RAS_DEPTH)
  - pop (ret & !call):
    - if cnt != 0: ptr <= ptr-1 (mod RAS_DEPTH), cnt <= cnt-1
    - if cnt == 0 (underflow): no change
  - pop-then-push (call & ret):
    - entry[ptr] <= pc+4; ptr and cnt unchanged
    - if cnt == 0: entry[ptr+1] <= pc+4, ptr <= ptr+1, cnt <= 1
  - no fire, or neither flag set: hold.
- Overflow: a push at cnt == RAS_DEPTH overwrites the oldest entry and leaves cnt saturated at RAS_DEPTH.
- Return address arithmetic: pc+4 in `CORE_XLEN` bits, wrapping modulo 2^XLEN; no compressed (+2) case.
- Flush:
  - When flush_i = 1, spec array, ptr and cnt <= the cmt values after this cycle's commit update. The retirement in the flush cycle is bypassed into the copy.
  - The fetch update in that cycle (if_vld_i) is discarded.
  - Flush has priority over fetch; commit is never blocked.
- Latency: push/pop visible on ras_tgt_o one cycle after fire. Flush restore is visible one cycle after flush_i.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronous).

Optional Feature:
- Macro: K423_RAS_RECUR_CNT_EN.
- Defined:
  - Each entry gains an 8-bit recursion counter (spec and cmt).
  - A push whose pc+4 equals the current top entry, with cnt != 0 and counter != 255, increments the top counter. No pointer or cnt change.
  - A pop with top counter != 0 decrements the counter only.
  - Flush copies the counters as well.
  - Counters reset to 0.
- Not defined:
  - No counters; every push allocates an entry exactly as above.

Test Plan:
- Reset, then fire call at if_pc_i = 0x100 -> next cycle ras_vld_o = 1, ras_tgt_o = 0x104, ras_cnt_o = 1. Then fire ret -> next cycle ras_vld_o = 0, ras_cnt_o = 0.
- Nine calls at PCs 0x1000, 0x1010, ... 0x1080 (RAS_DEPTH = 8) -> ras_cnt_o = 8, ras_tgt_o = 0x1084. Eight rets yield targets 0x1084 down to 0x1014. A ninth ret is an underflow with no pointer change.
- Ret on an empty stack -> ras_vld_o stays 0; a following call at 0x200 gives ras_tgt_o = 0x204, ras_cnt_o = 1.
- Call+ret in the same fire at 0x300 with top = 0x104 -> ras_tgt_o = 0x304, ras_cnt_o unchanged.
- Speculative calls at 0x400 and 0x500, committed call at 0x100 only, then flush_i -> next cycle ras_tgt_o = 0x104, ras_cnt_o = 1. Repeat with a cmt_call at 0x600 in the flush cycle -> ras_tgt_o = 0x604, ras_cnt_o = 2. A concurrent if_vld_i call in the flush cycle is ignored.
- With K423_RAS_RECUR_CNT_EN defined: two calls at 0x700 -> ras_cnt_o = 1. The first ret leaves ras_tgt_o = 0x704; the second ret empties the stack. Without the macro the same sequence gives ras_cnt_o = 2.

Source files
------------

// File: rtl/k423_if_ras.sv
// k423_if_ras: return address stack for the fetch-stage branch predictor.
//
// Two circular stacks are kept. The speculative stack is updated by the
// fetch-stage mini-decode (call/return flags and fetch PC). The committed
// stack is updated at retire. A flush reloads the speculative stack from the
// committed stack, including this cycle's retirement.
//
// Ports:
//   clk_i, rst_i       core clock, asynchronous active-high reset
//   flush_i            backend redirect: speculative <= committed (post-commit)
//   if_vld_i/if_pc_i   fetch accepted this cycle / its PC
//   dec_call_i/ret_i   mini-decode call / return flags
//   cmt_vld_i/cmt_pc_i retirement this cycle / its PC
//   cmt_call_i/ret_i   retiring instruction is a call / return
//   ras_vld_o          speculative stack non-empty
//   ras_tgt_o          speculative top entry (predicted return target)
//   ras_cnt_o          speculative occupancy
//
// Optional feature macro: K423_RAS_RECUR_CNT_EN
//   Adds an 8-bit recursion counter per entry, so repeated pushes of the same
//   return address bump a counter instead of allocating new entries.
//   Default build (macro undefined) has no counters.

`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif

module k423_if_ras #(
  parameter int RAS_DEPTH = 8,
  parameter int RAS_PTR_W = $clog2(RAS_DEPTH)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            if_vld_i,
  input  logic [`CORE_XLEN-1:0]           if_pc_i,
  input  logic                            dec_call_i,
  input  logic                            dec_ret_i,
  input  logic                            cmt_vld_i,
  input  logic [`CORE_XLEN-1:0]           cmt_pc_i,
  input  logic                            cmt_call_i,
  input  logic                            cmt_ret_i,
  output logic                            ras_vld_o,
  output logic [`CORE_XLEN-1:0]           ras_tgt_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0]  ras_cnt_o
);

  localparam int XLEN  = `CORE_XLEN;
  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  typedef logic [XLEN-1:0] addr_t;

  typedef struct packed {
    logic [RAS_DEPTH-1:0][XLEN-1:0] ent;
`ifdef K423_RAS_RECUR_CNT_EN
    logic [RAS_DEPTH-1:0][7:0]      rc;
`endif
    logic [RAS_PTR_W-1:0]           ptr;
    logic [CNT_W-1:0]               cnt;
  } stk_t;

  // Return address: no compressed-instruction case, wraps modulo 2^XLEN.
  function automatic addr_t ret_addr(addr_t pc);
    return pc + addr_t'(4);
  endfunction

  function automatic stk_t stk_reset();
    stk_t s;
    s     = '0;
    s.ptr = RAS_PTR_W'(RAS_DEPTH-1);
    return s;
  endfunction

  // One clock of stack update for a given {fire, call, ret, pc}.
  function automatic stk_t stk_step(stk_t s, logic fire, logic call, logic ret,
                                    addr_t pc);
    stk_t                 n;
    addr_t                ra;
    logic [RAS_PTR_W-1:0] up;
    logic                 bump;
    logic                 unwind;
    n      = s;
    ra     = ret_addr(pc);
    up     = s.ptr + RAS_PTR_W'(1);
    bump   = 1'b0;
    unwind = 1'b0;
`ifdef K423_RAS_RECUR_CNT_EN
    bump   = (s.cnt != '0) && (s.ent[s.ptr] == ra) && (s.rc[s.ptr] != 8'hFF);
    unwind = (s.cnt != '0) && (s.rc[s.ptr] != 8'h00);
`endif
    if (fire) begin
      if (call && !ret) begin
        if (bump) begin
`ifdef K423_RAS_RECUR_CNT_EN
          n.rc[s.ptr] = s.rc[s.ptr] + 8'd1;
`endif
        end else begin
          // When full, up already points at the oldest entry, so it is
          // overwritten and cnt stays saturated.
          n.ptr    = up;
          n.ent[up] = ra;
`ifdef K423_RAS_RECUR_CNT_EN
          n.rc[up] = 8'h00;
`endif
          if (s.cnt != CNT_W'(RAS_DEPTH))
            n.cnt = s.cnt + CNT_W'(1);
        end
      end else if (ret && !call) begin
        if (unwind) begin
`ifdef K423_RAS_RECUR_CNT_EN
          n.rc[s.ptr] = s.rc[s.ptr] - 8'd1;
`endif
        end else if (s.cnt != '0) begin
          n.ptr = s.ptr - RAS_PTR_W'(1);
          n.cnt = s.cnt - CNT_W'(1);
        end
      end else if (call && ret) begin
        // Pop-then-push collapses to replacing the top entry; on an empty
        // stack the pop is a no-op, so it degenerates to a plain push.
        n.ent[s.ptr] = ra;
`ifdef K423_RAS_RECUR_CNT_EN
        n.rc[s.ptr] = 8'h00;
`endif
        if (s.cnt == '0) begin
          n.ent[up] = ra;
`ifdef K423_RAS_RECUR_CNT_EN
          n.rc[up] = 8'h00;
`endif
          n.ptr = up;
          n.cnt = CNT_W'(1);
        end
      end
    end
    return n;
  endfunction

  stk_t spec_q;
  stk_t cmt_q;
  stk_t spec_d;
  stk_t cmt_d;

  // Commit is never blocked; flush takes the post-commit copy and discards
  // this cycle's fetch update.
  always_comb begin
    cmt_d  = stk_step(cmt_q, cmt_vld_i, cmt_call_i, cmt_ret_i, cmt_pc_i);
    spec_d = stk_step(spec_q, if_vld_i, dec_call_i, dec_ret_i, if_pc_i);
    if (flush_i)
      spec_d = cmt_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spec_q <= stk_reset();
      cmt_q  <= stk_reset();
    end else begin
      spec_q <= spec_d;
      cmt_q  <= cmt_d;
    end
  end

  assign ras_tgt_o = spec_q.ent[spec_q.ptr];
  assign ras_vld_o = (spec_q.cnt != '0);
  assign ras_cnt_o = spec_q.cnt;

endmodule

// File: tb/tb_k423_if_ras.sv
// Testbench for k423_if_ras: directed vector table, hand-written overflow /
// underflow / async-reset sequences, and randomized traffic against a
// queue-based reference model of both stacks.

`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif

module tb_k423_if_ras;

  localparam int DEPTH = 8;
  localparam int XLEN  = `CORE_XLEN;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            if_vld;
  logic [XLEN-1:0] if_pc;
  logic            dec_call;
  logic            dec_ret;
  logic            cmt_vld;
  logic [XLEN-1:0] cmt_pc;
  logic            cmt_call;
  logic            cmt_ret;
  logic            ras_vld;
  logic [XLEN-1:0] ras_tgt;
  logic [3:0]      ras_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  k423_if_ras #(.RAS_DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .if_vld_i   (if_vld),
    .if_pc_i    (if_pc),
    .dec_call_i (dec_call),
    .dec_ret_i  (dec_ret),
    .cmt_vld_i  (cmt_vld),
    .cmt_pc_i   (cmt_pc),
    .cmt_call_i (cmt_call),
    .cmt_ret_i  (cmt_ret),
    .ras_vld_o  (ras_vld),
    .ras_tgt_o  (ras_tgt),
    .ras_cnt_o  (ras_cnt)
  );

  // ---------------- reference model: stacks as queues (back = top)
  typedef struct {
    logic [XLEN-1:0] a;
    int              rc;
  } ent_t;
  typedef ent_t q_t[$];

  q_t mspec;
  q_t mcmt;

  function automatic q_t model_upd(q_t q, logic fire, logic call, logic ret,
                                   logic [XLEN-1:0] pc);
    q_t              r;
    logic [XLEN-1:0] ra;
    ent_t            e;
    logic            recur;
    r     = q;
    ra    = pc + 4;
    recur = 1'b0;
`ifdef K423_RAS_RECUR_CNT_EN
    recur = 1'b1;
`endif
    if (!fire) return r;
    if (call && !ret) begin
      if (recur && r.size() != 0 && r[$].a == ra && r[$].rc != 255) begin
        r[$].rc = r[$].rc + 1;
      end else begin
        e.a = ra; e.rc = 0;
        r.push_back(e);
        if (r.size() > DEPTH) void'(r.pop_front());
      end
    end else if (ret && !call) begin
      if (r.size() != 0) begin
        if (recur && r[$].rc != 0) r[$].rc = r[$].rc - 1;
        else void'(r.pop_back());
      end
    end else if (call && ret) begin
      e.a = ra; e.rc = 0;
      if (r.size() == 0) r.push_back(e);
      else r[$] = e;
    end
    return r;
  endfunction

  // ---------------- helpers
  task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic f, logic iv, logic ic, logic ir, logic [XLEN-1:0] ipc,
                       logic cv, logic cc, logic cr, logic [XLEN-1:0] cpc);
    flush = f; if_vld = iv; dec_call = ic; dec_ret = ir; if_pc = ipc;
    cmt_vld = cv; cmt_call = cc; cmt_ret = cr; cmt_pc = cpc;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    mspec.delete();
    mcmt.delete();
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic            f, iv, ic, ir;
    logic [XLEN-1:0] ipc;
    logic            cv, cc, cr;
    logic [XLEN-1:0] cpc;
    logic            evld;
    logic [XLEN-1:0] etgt;
    int              ecnt;
    logic            ctgt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic f, logic iv, logic ic, logic ir, logic [XLEN-1:0] ipc,
                              logic cv, logic cc, logic cr, logic [XLEN-1:0] cpc,
                              logic evld, logic [XLEN-1:0] etgt, int ecnt, logic ctgt);
    vec_t v;
    v.f = f; v.iv = iv; v.ic = ic; v.ir = ir; v.ipc = ipc;
    v.cv = cv; v.cc = cc; v.cr = cr; v.cpc = cpc;
    v.evld = evld; v.etgt = etgt; v.ecnt = ecnt; v.ctgt = ctgt;
    return v;
  endfunction

  int recur_cnt2;

  initial begin
    rst = 1'b1;
    idle();

`ifdef K423_RAS_RECUR_CNT_EN
    recur_cnt2 = 1;
`else
    recur_cnt2 = 2;
`endif

    //         f  iv ic ir ipc          cv cc cr cpc         vld tgt          cnt chk
    tbl.push_back(mk(0, 1, 1, 0, 32'h100, 0, 0, 0, 32'h0,   1, 32'h104, 1, 1)); // call
    tbl.push_back(mk(0, 1, 0, 1, 32'h108, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0)); // ret
    tbl.push_back(mk(0, 1, 0, 1, 32'h10,  0, 0, 0, 32'h0,   0, 32'h0,   0, 0)); // underflow
    tbl.push_back(mk(0, 1, 1, 0, 32'h200, 0, 0, 0, 32'h0,   1, 32'h204, 1, 1)); // call
    tbl.push_back(mk(0, 1, 1, 1, 32'h300, 0, 0, 0, 32'h0,   1, 32'h304, 1, 1)); // call+ret
    tbl.push_back(mk(0, 0, 1, 0, 32'h900, 0, 0, 0, 32'h0,   1, 32'h304, 1, 1)); // no fire
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 0)); // flush, empty cmt
    tbl.push_back(mk(0, 1, 1, 0, 32'h700, 0, 0, 0, 32'h0,   1, 32'h704, 1, 1)); // recursion
    tbl.push_back(mk(0, 1, 1, 0, 32'h700, 0, 0, 0, 32'h0,   1, 32'h704, recur_cnt2, 1));
    tbl.push_back(mk(0, 1, 0, 1, 32'h7f0, 0, 0, 0, 32'h0,   1, 32'h704, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 32'h7f0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h400, 1, 1, 0, 32'h100, 1, 32'h404, 1, 1)); // spec 0x400, cmt 0x100
    tbl.push_back(mk(0, 1, 1, 0, 32'h500, 0, 0, 0, 32'h0,   1, 32'h504, 2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h104, 1, 1)); // flush restore
    tbl.push_back(mk(0, 1, 1, 0, 32'h400, 0, 0, 0, 32'h0,   1, 32'h404, 2, 1));
    tbl.push_back(mk(1, 1, 1, 0, 32'h900, 1, 1, 0, 32'h600, 1, 32'h604, 2, 1)); // flush + bypassed commit
    tbl.push_back(mk(0, 1, 0, 1, 32'h0,   0, 0, 0, 32'h0,   1, 32'h104, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 1, 32'h0, 2, 1)); // pc+4 wraps

    repeat (2) @(posedge clk);
    #1;
    chk("reset_vld", {31'b0, ras_vld}, 32'h0);
    chk("reset_tgt", ras_tgt, 32'h0);
    chk("reset_cnt", 32'(ras_cnt), 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].f, tbl[i].iv, tbl[i].ic, tbl[i].ir, tbl[i].ipc,
            tbl[i].cv, tbl[i].cc, tbl[i].cr, tbl[i].cpc);
      step();
      chk($sformatf("tbl%0d_vld", i), {31'b0, ras_vld}, {31'b0, tbl[i].evld});
      chk($sformatf("tbl%0d_cnt", i), 32'(ras_cnt), 32'(tbl[i].ecnt));
      if (tbl[i].ctgt)
        chk($sformatf("tbl%0d_tgt", i), ras_tgt, tbl[i].etgt);
    end
    idle();

    // Asynchronous reset between clock edges (stack holds 2 entries here).
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_vld", {31'b0, ras_vld}, 32'h0);
    chk("async_rst_tgt", ras_tgt, 32'h0);
    chk("async_rst_cnt", 32'(ras_cnt), 32'h0);
    step();
    rst = 1'b0;

    // Overflow: nine calls, then eight returns, then an underflow.
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 1, 0, 32'h1000 + 32'(i) * 32'h10, 0, 0, 0, '0);
      step();
    end
    chk("ovf_cnt", 32'(ras_cnt), 32'd8);
    chk("ovf_tgt", ras_tgt, 32'h1084);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pop%0d_tgt", i), ras_tgt, 32'h1084 - 32'(i) * 32'h10);
      drive(0, 1, 0, 1, 32'h3000, 0, 0, 0, '0);
      step();
      chk($sformatf("pop%0d_cnt", i), 32'(ras_cnt), 32'(7 - i));
    end
    // Pointer has wrapped back to slot 0, which holds the ninth push.
    drive(0, 1, 0, 1, 32'h3000, 0, 0, 0, '0);
    step();
    chk("udf_vld", {31'b0, ras_vld}, 32'h0);
    chk("udf_cnt", 32'(ras_cnt), 32'h0);
    chk("udf_tgt", ras_tgt, 32'h1084);
    idle();

    // Randomized traffic against the queue model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic            f, iv, ic, ir, cv, cc, cr;
      logic [XLEN-1:0] ipc, cpc;
      f   = ($urandom_range(0, 15) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      ic  = $urandom_range(0, 1) == 1;
      ir  = $urandom_range(0, 2) == 0;
      ipc = 32'h2000 + 32'($urandom_range(0, 5)) * 32'h10;
      cv  = ($urandom_range(0, 1) == 1);
      cc  = $urandom_range(0, 1) == 1;
      cr  = $urandom_range(0, 2) == 0;
      cpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                                        : 32'h5000 + 32'($urandom_range(0, 5)) * 32'h10;
      drive(f, iv, ic, ir, ipc, cv, cc, cr, cpc);
      step();
      mcmt = model_upd(mcmt, cv, cc, cr, cpc);
      if (f) mspec = mcmt;
      else   mspec = model_upd(mspec, iv, ic, ir, ipc);
      chk($sformatf("rnd%0d_cnt", n), 32'(ras_cnt), 32'(mspec.size()));
      chk($sformatf("rnd%0d_vld", n), {31'b0, ras_vld}, {31'b0, mspec.size() != 0});
      if (mspec.size() != 0)
        chk($sformatf("rnd%0d_tgt", n), ras_tgt, mspec[$].a);
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
